// File: rtl/fast_segment_test.sv
// FAST-9 segment test stage: reads the smoothed image from the conv SRAM in
// raster order and writes one corner byte per pixel into the FAST SRAM.
// All outputs are registered. Their next values are decoded from the next
// state, so each output is valid in the same cycle as the state it belongs to.
module fast_segment_test #(
  parameter int X_MAX       = 400,
  parameter int Y_MAX       = 400,
  parameter int PIXEL_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [PIXEL_DEPTH-1:0]   threshold,
  input  logic [$clog2(X_MAX):0]   max_x,
  input  logic [$clog2(Y_MAX):0]   max_y,
  output logic [$clog2(X_MAX):0]   x_addr_conv_fast,
  output logic [$clog2(Y_MAX):0]   y_addr_conv_fast,
  output logic                     ren_conv_fast,
  input  logic [PIXEL_DEPTH-1:0]   rdat_conv_fast,
  output logic [$clog2(X_MAX):0]   x_addr_fast,
  output logic [$clog2(Y_MAX):0]   y_addr_fast,
  output logic                     wen_fast,
  output logic [PIXEL_DEPTH-1:0]   wdat_fast,
  output logic                     busy,
  output logic                     done
);

  localparam int XW = $clog2(X_MAX) + 1;
  localparam int YW = $clog2(Y_MAX) + 1;
  localparam int PD = PIXEL_DEPTH;

  // SEL is only ever entered for border pixels; interior pixels go straight
  // to READ, so the border/interior decision costs no cycle of its own.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEL   = 3'd1,
    S_READ  = 3'd2,
    S_CAP   = 3'd3,
    S_EVAL  = 3'd4,
    S_WRITE = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [PD-1:0]   thr_q, thr_d;
  logic [XW-1:0]   mx_q, mx_d;
  logic [YW-1:0]   my_q, my_d;
  logic [XW-1:0]   cx_q, cx_d;
  logic [YW-1:0]   cy_q, cy_d;
  logic [4:0]      k_q, k_d;
  logic            corner_q, corner_d;
  logic [PD-1:0]   pix_q [0:16];
  logic [PD-1:0]   pix_d [0:16];

  logic [XW-1:0]   xrc_q, xrc_d;
  logic [YW-1:0]   yrc_q, yrc_d;
  logic            ren_q, ren_d;
  logic [XW-1:0]   xw_q, xw_d;
  logic [YW-1:0]   yw_q, yw_d;
  logic            wen_q, wen_d;
  logic [PD-1:0]   wdat_q, wdat_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [XW-1:0]   nx_s;
  logic [YW-1:0]   ny_s;
  logic            last_s;
  logic            nborder_s;
  logic [15:0]     bright_s;
  logic [15:0]     dark_s;
  logic            corner_calc_s;

  // Read index k: 0 is the centre, 1..16 walk the radius-3 circle clockwise from north.
  function automatic logic signed [3:0] off_x(input logic [4:0] k);
    logic signed [3:0] r;
    case (k)
      5'd0:    r = 4'sd0;
      5'd1:    r = 4'sd0;
      5'd2:    r = 4'sd1;
      5'd3:    r = 4'sd2;
      5'd4:    r = 4'sd3;
      5'd5:    r = 4'sd3;
      5'd6:    r = 4'sd3;
      5'd7:    r = 4'sd2;
      5'd8:    r = 4'sd1;
      5'd9:    r = 4'sd0;
      5'd10:   r = -4'sd1;
      5'd11:   r = -4'sd2;
      5'd12:   r = -4'sd3;
      5'd13:   r = -4'sd3;
      5'd14:   r = -4'sd3;
      5'd15:   r = -4'sd2;
      5'd16:   r = -4'sd1;
      default: r = 4'sd0;
    endcase
    return r;
  endfunction

  function automatic logic signed [3:0] off_y(input logic [4:0] k);
    logic signed [3:0] r;
    case (k)
      5'd0:    r = 4'sd0;
      5'd1:    r = -4'sd3;
      5'd2:    r = -4'sd3;
      5'd3:    r = -4'sd2;
      5'd4:    r = -4'sd1;
      5'd5:    r = 4'sd0;
      5'd6:    r = 4'sd1;
      5'd7:    r = 4'sd2;
      5'd8:    r = 4'sd3;
      5'd9:    r = 4'sd3;
      5'd10:   r = 4'sd3;
      5'd11:   r = 4'sd2;
      5'd12:   r = 4'sd1;
      5'd13:   r = 4'sd0;
      5'd14:   r = -4'sd1;
      5'd15:   r = -4'sd2;
      5'd16:   r = -4'sd3;
      default: r = 4'sd0;
    endcase
    return r;
  endfunction

  // Reads are issued only for interior pixels, so base+offset never leaves the image.
  function automatic logic [XW-1:0] add_off_x(input logic [XW-1:0] base, input logic signed [3:0] off);
    return XW'($signed({2'b00, base}) + (XW+2)'(off));
  endfunction

  function automatic logic [YW-1:0] add_off_y(input logic [YW-1:0] base, input logic signed [3:0] off);
    return YW'($signed({2'b00, base}) + (YW+2)'(off));
  endfunction

  // The right/bottom test is written as x+3 > max so it cannot wrap.
  function automatic logic is_border(input logic [XW-1:0] x, input logic [YW-1:0] y,
                                     input logic [XW-1:0] mx, input logic [YW-1:0] my);
    logic r;
    r = (mx < XW'(6)) || (my < YW'(6)) ||
        (x < XW'(3)) || (y < YW'(3)) ||
        (({1'b0, x} + (XW+1)'(3)) > {1'b0, mx}) ||
        (({1'b0, y} + (YW+1)'(3)) > {1'b0, my});
    return r;
  endfunction

  // True when 9 or more circularly contiguous flags are set (index 15 touches index 0).
  function automatic logic has_arc(input logic [15:0] f);
    logic [31:0] ff;
    logic        found;
    ff    = {f, f};
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (&ff[i +: 9]) begin
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return found;
  endfunction

  // Raster successor of the current pixel and its border classification.
  always_comb begin
    last_s = (cx_q == mx_q) && (cy_q == my_q);
    if (cx_q == mx_q) begin
      nx_s = '0;
      ny_s = cy_q + YW'(1);
    end else begin
      nx_s = cx_q + XW'(1);
      ny_s = cy_q;
    end
    nborder_s = is_border(nx_s, ny_s, mx_q, my_q);
  end

  // Segment test: flag each circle pixel brighter/darker than the centre, in PD+1 bits.
  always_comb begin
    bright_s = '0;
    dark_s   = '0;
    for (int i = 0; i < 16; i++) begin
      bright_s[i] = {1'b0, pix_q[i+1]} > ({1'b0, pix_q[0]} + {1'b0, thr_q});
      dark_s[i]   = ({1'b0, pix_q[i+1]} + {1'b0, thr_q}) < {1'b0, pix_q[0]};
    end
    corner_calc_s = has_arc(bright_s) || has_arc(dark_s);
  end

  // Next-state logic: sequencing, pixel counters, latched parameters and corner decision.
  always_comb begin
    state_d  = state_q;
    thr_d    = thr_q;
    mx_d     = mx_q;
    my_d     = my_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    k_d      = k_q;
    corner_d = corner_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          thr_d   = threshold;
          mx_d    = max_x;
          my_d    = max_y;
          cx_d    = '0;
          cy_d    = '0;
          state_d = S_SEL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEL, S_WRITE: begin
        if (last_s) begin
          state_d = S_DONE;
        end else begin
          cx_d    = nx_s;
          cy_d    = ny_s;
          k_d     = 5'd0;
          state_d = nborder_s ? S_SEL : S_READ;
        end
      end
      S_READ: begin
        if (k_q == 5'd16) begin
          state_d = S_CAP;
        end else begin
          k_d = k_q + 5'd1;
        end
      end
      S_CAP: begin
        state_d = S_EVAL;
      end
      S_EVAL: begin
        corner_d = corner_calc_s;
        state_d  = S_WRITE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Capture read data one cycle after each read: index k lands while k+1 issues, index 16 in CAP.
  always_comb begin
    pix_d = pix_q;
    if ((state_q == S_READ) && (k_q != 5'd0)) begin
      pix_d[k_q - 5'd1] = rdat_conv_fast;
    end else if (state_q == S_CAP) begin
      pix_d[16] = rdat_conv_fast;
    end else begin
      pix_d = pix_q;
    end
  end

  // Output decode from the next state so the registered outputs line up with that state.
  always_comb begin
    ren_d  = (state_d == S_READ);
    wen_d  = (state_d == S_SEL) || (state_d == S_WRITE);
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
    if (ren_d) begin
      xrc_d = add_off_x(cx_d, off_x(k_d));
      yrc_d = add_off_y(cy_d, off_y(k_d));
    end else begin
      xrc_d = '0;
      yrc_d = '0;
    end
    if (wen_d) begin
      xw_d = cx_d;
      yw_d = cy_d;
    end else begin
      xw_d = '0;
      yw_d = '0;
    end
    if ((state_d == S_WRITE) && corner_d) begin
      wdat_d = '1;
    end else begin
      wdat_d = '0;
    end
  end

  // State, datapath and output registers; reset aborts any image in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      thr_q    <= '0;
      mx_q     <= '0;
      my_q     <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      k_q      <= 5'd0;
      corner_q <= 1'b0;
      for (int i = 0; i < 17; i++) begin
        pix_q[i] <= '0;
      end
      xrc_q    <= '0;
      yrc_q    <= '0;
      ren_q    <= 1'b0;
      xw_q     <= '0;
      yw_q     <= '0;
      wen_q    <= 1'b0;
      wdat_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      thr_q    <= thr_d;
      mx_q     <= mx_d;
      my_q     <= my_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      k_q      <= k_d;
      corner_q <= corner_d;
      for (int i = 0; i < 17; i++) begin
        pix_q[i] <= pix_d[i];
      end
      xrc_q    <= xrc_d;
      yrc_q    <= yrc_d;
      ren_q    <= ren_d;
      xw_q     <= xw_d;
      yw_q     <= yw_d;
      wen_q    <= wen_d;
      wdat_q   <= wdat_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign x_addr_conv_fast = xrc_q;
  assign y_addr_conv_fast = yrc_q;
  assign ren_conv_fast    = ren_q;
  assign x_addr_fast      = xw_q;
  assign y_addr_fast      = yw_q;
  assign wen_fast         = wen_q;
  assign wdat_fast        = wdat_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule
